sram_port_ctrl: RTL

//  Initiator front-end for the OpenRAM single-port macro (csb0/web0/addr0/din0/dout0 on clk0).

---
 rtl/sram_ctrl_pkg.sv | 24 ++
 rtl/sram_port_ctrl_if.sv | 26 ++
 rtl/sram_ctrl_rsp_fifo.sv | 60 ++++++
 rtl/sram_port_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM port controller.
// Contents: bist_state_e (BIST sequencer states) and bist_pattern(), the
// per-address data pattern written and expected by the optional BIST.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    BIST_IDLE  = 3'd0,
    BIST_DRAIN = 3'd1,
    BIST_WRITE = 3'd2,
    BIST_READ  = 3'd3,
    BIST_FLUSH = 3'd4,
    BIST_DONE  = 3'd5
  } bist_state_e;

  // Wide enough for any practical address/data width; callers truncate.
  localparam int unsigned PAT_W = 32;

  // Pattern for address a: low data bits of the address XOR the seed.
  function automatic logic [PAT_W-1:0] bist_pattern(input logic [PAT_W-1:0] addr,
                                                     input logic [PAT_W-1:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/sram_port_ctrl_if.sv
// Request/response stream bundle between an initiator and sram_port_ctrl.
// master: initiator side (drives req_*, rsp_ready).
// slave : controller side (drives req_ready, rsp_valid, rsp_rdata).
interface sram_port_ctrl_if #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_ctrl_rsp_fifo.sv
// Synchronous response FIFO with occupancy count.
// Ports: clk/rst (async active-high), push/push_data, pop/pop_data
// (head entry, valid while count!=0), count (entries held).
// Push and pop in the same cycle keep the count and preserve order;
// pop when empty is ignored; push when full is dropped unless a pop frees a slot.
module sram_ctrl_rsp_fifo #(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Qualify push/pop against current occupancy.
  always_comb begin
    do_pop_s  = pop & (count_r != '0);
    do_push_s = push & ((count_r != CW'(DEPTH)) | do_pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign count    = count_r;
endmodule

// File: rtl/sram_port_ctrl.sv
// Initiator front-end for an OpenRAM single-port macro.
// Ports: clk0, rst0 (async active-high); bus (sram_port_ctrl_if.slave:
// request stream in, read-response stream out); sram_csb0/web0/addr0/din0
// (registered macro controls), sram_dout0 (macro read data).
// A request accepted at edge N drives the port registers at N; the macro
// samples at N+1 and read data is captured into the response FIFO at N+2.
// Reads are credit limited to RSP_DEPTH outstanding; writes never are.
// Optional macro SRAM_BIST_EN adds bist_start/busy/done/fail/fail_addr and a
// write-then-read-back self test over the full address range.
module sram_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = 2,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    RSP_DEPTH  = 2,
  parameter logic [DATA_WIDTH-1:0] BIST_SEED  = DATA_WIDTH'(2'b01)
) (
  input  logic                  clk0,
  input  logic                  rst0,
  sram_port_ctrl_if.slave       bus,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
`ifdef SRAM_BIST_EN
  ,
  input  logic                  bist_start,
  output logic                  bist_busy,
  output logic                  bist_done,
  output logic                  bist_fail,
  output logic [ADDR_WIDTH-1:0] bist_fail_addr
`endif
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int OW = CW + 2;

  logic                  accept_s;
  logic                  req_ready_s;
  logic                  host_block_s;
  logic                  rd_p1_r;
  logic                  rd_p2_r;
  logic [CW-1:0]         fifo_count_s;
  logic [OW-1:0]         outstanding_s;
  logic                  issue_s;
  logic                  issue_we_s;
  logic [ADDR_WIDTH-1:0] issue_addr_s;
  logic [DATA_WIDTH-1:0] issue_data_s;

`ifdef SRAM_BIST_EN
  bist_state_e           state_r;
  bist_state_e           state_nxt_s;
  logic [ADDR_WIDTH-1:0] bist_addr_r;
  logic                  bist_issue_s;
  logic                  bist_we_s;
  logic                  bist_last_s;
  logic [DATA_WIDTH-1:0] bist_pat_s;
  logic [DATA_WIDTH-1:0] bist_exp_s;
  logic                  cmp_p1_r;
  logic                  cmp_p2_r;
  logic [ADDR_WIDTH-1:0] cmp_a1_r;
  logic [ADDR_WIDTH-1:0] cmp_a2_r;
  logic                  fail_r;
  logic [ADDR_WIDTH-1:0] fail_addr_r;

  assign host_block_s = (state_r == BIST_DRAIN) || (state_r == BIST_WRITE) ||
                        (state_r == BIST_READ)  || (state_r == BIST_FLUSH);
  assign bist_last_s  = (bist_addr_r == {ADDR_WIDTH{1'b1}});
  assign bist_pat_s   = DATA_WIDTH'(bist_pattern(PAT_W'(bist_addr_r), PAT_W'(BIST_SEED)));
  assign bist_exp_s   = DATA_WIDTH'(bist_pattern(PAT_W'(cmp_a2_r), PAT_W'(BIST_SEED)));

  // BIST next-state and port-issue decode.
  always_comb begin
    state_nxt_s  = state_r;
    bist_issue_s = 1'b0;
    bist_we_s    = 1'b0;
    case (state_r)
      BIST_IDLE:  if (bist_start) state_nxt_s = BIST_DRAIN; else state_nxt_s = BIST_IDLE;
      BIST_DRAIN: if (outstanding_s == '0) state_nxt_s = BIST_WRITE; else state_nxt_s = BIST_DRAIN;
      BIST_WRITE: begin
        bist_issue_s = 1'b1;
        bist_we_s    = 1'b1;
        if (bist_last_s) state_nxt_s = BIST_READ; else state_nxt_s = BIST_WRITE;
      end
      BIST_READ: begin
        bist_issue_s = 1'b1;
        if (bist_last_s) state_nxt_s = BIST_FLUSH; else state_nxt_s = BIST_READ;
      end
      // Wait for the compare pipeline to empty before reporting.
      BIST_FLUSH: if (!cmp_p1_r && !cmp_p2_r) state_nxt_s = BIST_DONE; else state_nxt_s = BIST_FLUSH;
      BIST_DONE:  if (bist_start) state_nxt_s = BIST_DRAIN; else state_nxt_s = BIST_DONE;
      default:    state_nxt_s = BIST_IDLE;
    endcase
  end

  // BIST state, address walker, compare pipeline and fail capture.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_r     <= BIST_IDLE;
      bist_addr_r <= '0;
      cmp_p1_r    <= 1'b0;
      cmp_p2_r    <= 1'b0;
      cmp_a1_r    <= '0;
      cmp_a2_r    <= '0;
      fail_r      <= 1'b0;
      fail_addr_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      // Natural wrap from all-ones back to zero ends each phase.
      if (bist_issue_s) bist_addr_r <= bist_addr_r + ADDR_WIDTH'(1);
      else              bist_addr_r <= '0;
      cmp_p1_r <= bist_issue_s & ~bist_we_s;
      cmp_a1_r <= bist_addr_r;
      cmp_p2_r <= cmp_p1_r;
      cmp_a2_r <= cmp_a1_r;
      if (((state_r == BIST_IDLE) || (state_r == BIST_DONE)) && bist_start) begin
        fail_r      <= 1'b0;
        fail_addr_r <= '0;
      end else if (cmp_p2_r && !fail_r && (sram_dout0 != bist_exp_s)) begin
        fail_r      <= 1'b1;
        fail_addr_r <= cmp_a2_r;
      end
    end
  end

  assign bist_busy      = host_block_s;
  assign bist_done      = (state_r == BIST_DONE);
  assign bist_fail      = fail_r;
  assign bist_fail_addr = fail_addr_r;
`else
  assign host_block_s = 1'b0;
`endif

  // Credits: reads in the two pipeline stages plus responses still queued.
  always_comb begin
    outstanding_s = OW'(fifo_count_s) + OW'(rd_p1_r) + OW'(rd_p2_r);
    req_ready_s   = ~host_block_s & ((outstanding_s < OW'(RSP_DEPTH)) | bus.req_we);
    accept_s      = bus.req_valid & req_ready_s;
  end

  // Select who drives the macro this cycle: host request or BIST walker.
  always_comb begin
    issue_s      = accept_s;
    issue_we_s   = bus.req_we;
    issue_addr_s = bus.req_addr;
    issue_data_s = bus.req_wdata;
`ifdef SRAM_BIST_EN
    if (bist_issue_s) begin
      issue_s      = 1'b1;
      issue_we_s   = bist_we_s;
      issue_addr_s = bist_addr_r;
      issue_data_s = bist_pat_s;
    end else begin
      issue_s      = accept_s;
    end
`endif
  end

  // Macro port registers and host read-tracking pipeline.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
      rd_p1_r    <= 1'b0;
      rd_p2_r    <= 1'b0;
    end else begin
      sram_csb0 <= ~issue_s;
      sram_web0 <= ~(issue_s & issue_we_s);
      if (issue_s) begin
        sram_addr0 <= issue_addr_s;
        sram_din0  <= issue_data_s;
      end
      rd_p1_r <= accept_s & ~bus.req_we;
      rd_p2_r <= rd_p1_r;
    end
  end

  // Macro output is valid two edges after accept; queue it here.
  sram_ctrl_rsp_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk0),
    .rst      (rst0),
    .push     (rd_p2_r),
    .push_data(sram_dout0),
    .pop      (bus.rsp_valid & bus.rsp_ready),
    .pop_data (bus.rsp_rdata),
    .count    (fifo_count_s)
  );

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = (fifo_count_s != '0);
endmodule
